// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative M-extension sequencer and the
// EX-stage alu it borrows.
//   alu_op_e   : 4-bit alu operation encoding (shared with alu)
//   m_funct3_e : RISC-V M-extension funct3 encodings
//   state_e    : sequencer FSM states
//   MUL_LAT / DIV_LAT : accept-to-response latencies in cycles
// ----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SUB  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_SRA  = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_STEP = 3'd1,
        NEG_A    = 3'd2,
        NEG_B    = 3'd3,
        DIV_CMP  = 3'd4,
        DIV_SUB  = 3'd5,
        FIX      = 3'd6,
        DONE     = 3'd7
    } state_e;

    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 68;

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational EX-stage ALU.
//   Operation : alu_op_e encoding
//   SrcA/SrcB : 32-bit operands
//   ALUResult : 32-bit result (SLT/SLTU return 0/1 in bit 0)
// ----------------------------------------------------------------------------
module alu
    import muldiv_pkg::*;
(
    input  logic [3:0]  Operation,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] ALUResult
);

    // Straight decode of the operation code; unknown codes return zero.
    always_comb begin
        ALUResult = '0;
        case (Operation)
            ALU_AND:  ALUResult = SrcA & SrcB;
            ALU_OR:   ALUResult = SrcA | SrcB;
            ALU_ADD:  ALUResult = SrcA + SrcB;
            ALU_XOR:  ALUResult = SrcA ^ SrcB;
            ALU_SUB:  ALUResult = SrcA - SrcB;
            ALU_SLL:  ALUResult = SrcA << SrcB[4:0];
            ALU_SRL:  ALUResult = SrcA >> SrcB[4:0];
            ALU_SLT:  ALUResult = {31'b0, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: ALUResult = {31'b0, SrcA < SrcB};
            ALU_SRA:  ALUResult = $unsigned($signed(SrcA) >>> SrcB[4:0]);
            default:  ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// ----------------------------------------------------------------------------
// muldiv_seq
// Iterative MUL/DIV/DIVU/REM/REMU sequencer that owns the operand inputs of
// the EX-stage alu. Idle: pipeline operands pass straight through. Busy: it
// drives ADD/SUB/SLTU itself to run shift-add multiply or restoring divide,
// and holds the pipeline with o_stall.
// Ports:
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_req_valid / o_req_ready  : request handshake (ready only in IDLE)
//   i_req_funct3, i_req_a/b    : M-op funct3 and rs1/rs2 values
//   o_resp_valid               : one-cycle completion pulse
//   o_resp_data, o_resp_err    : result (held), unsupported-funct3 flag
//   o_stall                    : pipeline hold
//   i_ex_alu_op/a/b            : pipeline alu request
//   o_alu_op/a/b, i_alu_result : connection to the shared alu
// ----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_a,
    input  logic [XLEN-1:0] i_req_b,
    output logic            o_resp_valid,
    output logic [XLEN-1:0] o_resp_data,
    output logic            o_resp_err,
    output logic            o_stall,
    input  logic [3:0]      i_ex_alu_op,
    input  logic [XLEN-1:0] i_ex_alu_a,
    input  logic [XLEN-1:0] i_ex_alu_b,
    output logic [3:0]      o_alu_op,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    input  logic [XLEN-1:0] i_alu_result
);

    state_e          r_state;
    state_e          w_next_state;

    // r_opa: multiplicand for MUL, dividend then quotient for DIV/REM.
    // r_opb: multiplier for MUL, divisor magnitude for DIV/REM.
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_resp_data;
    logic [4:0]      r_cnt;
    logic            r_carry;
    logic            r_lt;
    logic            r_sa;
    logic            r_sb;
    logic            r_is_rem;
    logic            r_err;

    logic            w_accept;
    logic            w_signed_op;
    logic            w_unsupported;
    logic            w_take_sub;
    logic [XLEN-1:0] w_rem_shift;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;

    assign w_accept      = i_req_valid && (r_state == IDLE);
    // DIV (100) and REM (110) are the signed ops.
    assign w_signed_op   = i_req_funct3[2] & ~i_req_funct3[0];
    // funct3 001/010/011 (high-word multiplies) get an error response.
    assign w_unsupported = ~i_req_funct3[2] & (i_req_funct3[1] | i_req_funct3[0]);

    // Each divide pair starts by shifting {carry, R, Q} left by one; the SLTU
    // in DIV_CMP already sees the shifted remainder.
    assign w_rem_shift   = {r_rem[XLEN-2:0], r_opa[XLEN-1]};
    // A carry out of R means the true remainder exceeds 2^32 > D, so the
    // subtraction must happen regardless of the SLTU outcome.
    assign w_take_sub    = r_carry || !r_lt;

    // Sign restoration after the magnitude divide; divide-by-zero keeps the
    // all-ones quotient untouched.
    assign w_quo_fix = ((r_sa ^ r_sb) && (r_opb != '0)) ? (~r_opa + XLEN'(1)) : r_opa;
    assign w_rem_fix = r_sa ? (~r_rem + XLEN'(1)) : r_rem;

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = (r_state == DONE);
    assign o_resp_err   = (r_state == DONE) && r_err;
    assign o_resp_data  = r_resp_data;
    assign o_stall      = (r_state != IDLE) || i_req_valid;
    assign o_alu_op     = w_alu_op;
    assign o_alu_a      = w_alu_a;
    assign o_alu_b      = w_alu_b;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus ownership of the alu operands. Idle passes the
    // pipeline request through; every busy state drives the alu itself.
    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALU_ADD;
        w_alu_a      = '0;
        w_alu_b      = '0;
        case (r_state)
            IDLE: begin
                w_alu_op = i_ex_alu_op;
                w_alu_a  = i_ex_alu_a;
                w_alu_b  = i_ex_alu_b;
                if (i_req_valid) begin
                    if (i_req_funct3 == F3_MUL) begin
                        w_next_state = MUL_STEP;
                    end else if (i_req_funct3[2]) begin
                        w_next_state = NEG_A;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            MUL_STEP: begin
                w_alu_op = ALU_ADD;
                w_alu_a  = r_acc;
                w_alu_b  = r_opa;
                if (r_cnt == 5'd31) begin
                    w_next_state = DONE;
                end
            end
            NEG_A: begin
                w_alu_op     = ALU_SUB;
                w_alu_b      = r_opa;
                w_next_state = NEG_B;
            end
            NEG_B: begin
                w_alu_op     = ALU_SUB;
                w_alu_b      = r_opb;
                w_next_state = DIV_CMP;
            end
            DIV_CMP: begin
                w_alu_op     = ALU_SLTU;
                w_alu_a      = w_rem_shift;
                w_alu_b      = r_opb;
                w_next_state = DIV_SUB;
            end
            DIV_SUB: begin
                w_alu_op = ALU_SUB;
                w_alu_a  = r_rem;
                w_alu_b  = r_opb;
                if (r_cnt == 5'd31) begin
                    w_next_state = FIX;
                end else begin
                    w_next_state = DIV_CMP;
                end
            end
            FIX: begin
                w_next_state = DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. Results are loaded into r_resp_data on the edge
    // that enters DONE so they are visible during the response pulse and
    // stay there until a later operation overwrites them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_resp_data <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_lt        <= 1'b0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_is_rem    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opa    <= i_req_a;
                        r_opb    <= i_req_b;
                        r_acc    <= '0;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_carry  <= 1'b0;
                        r_lt     <= 1'b0;
                        r_sa     <= w_signed_op & i_req_a[XLEN-1];
                        r_sb     <= w_signed_op & i_req_b[XLEN-1];
                        r_is_rem <= i_req_funct3[1];
                        r_err    <= w_unsupported;
                        if (w_unsupported) begin
                            r_resp_data <= '0;
                        end
                    end
                end
                MUL_STEP: begin
                    if (r_opb[0]) begin
                        r_acc <= i_alu_result;
                    end
                    r_opa <= r_opa << 1;
                    r_opb <= r_opb >> 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_resp_data <= r_opb[0] ? i_alu_result : r_acc;
                    end
                end
                NEG_A: begin
                    if (r_sa) begin
                        r_opa <= i_alu_result;
                    end
                end
                NEG_B: begin
                    if (r_sb) begin
                        r_opb <= i_alu_result;
                    end
                end
                DIV_CMP: begin
                    r_carry <= r_rem[XLEN-1];
                    r_rem   <= w_rem_shift;
                    r_opa   <= {r_opa[XLEN-2:0], 1'b0};
                    r_lt    <= i_alu_result[0];
                end
                DIV_SUB: begin
                    if (w_take_sub) begin
                        r_rem    <= i_alu_result;
                        r_opa[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    r_resp_data <= r_is_rem ? w_rem_fix : w_quo_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// ----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed bench for muldiv_seq wired to the real alu. Expected results come
// from a behavioural reference model and are queued when a request is driven,
// then popped and compared when the response pulse appears.
// ----------------------------------------------------------------------------
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        stall;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_alu_a;
    logic [31:0] ex_alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    exp_t sb[$];
    int   testCnt = 0;
    int   failCnt = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_funct3 (req_funct3),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err),
        .o_stall      (stall),
        .i_ex_alu_op  (ex_alu_op),
        .i_ex_alu_a   (ex_alu_a),
        .i_ex_alu_b   (ex_alu_b),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
    );

    alu u_alu (
        .Operation (alu_op),
        .SrcA      (alu_a),
        .SrcB      (alu_b),
        .ALUResult (alu_result)
    );

    // Behavioural RISC-V M-extension reference.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic               ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000:  return 32'(a * b);
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sbv));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : (a / b);
            3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sbv));
            3'b111:  return (b == 0) ? a : (a % b);
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for the response and score it.
    // pokeBusy pulses req_valid mid-operation, which must be ignored.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input bit pokeBusy);
        exp_t e;
        int   lat;
        int   stallCnt;
        e.data = refModel(f3, a, b);
        e.err  = ~f3[2] & (f3[1] | f3[0]);
        e.lat  = (f3 == 3'b000) ? MUL_LAT : (f3[2] ? DIV_LAT : 1);
        sb.push_back(e);

        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        #1;
        checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
        stallCnt = stall ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom_range(0, 7));
        req_a      = $urandom();
        req_b      = $urandom();
        lat = 1;
        while (!resp_valid && lat < 200) begin
            if (stall) stallCnt++;
            if (pokeBusy && lat == 5) begin
                checkOutput({tag, " busy ready"}, 32'(req_ready), 32'd0);
                req_funct3 = 3'b000;
                req_valid  = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        if (resp_valid && stall) stallCnt++;

        e = sb.pop_front();
        checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, " latency"}, 32'(lat), 32'(e.lat));
        checkOutput({tag, " data"}, resp_data, e.data);
        checkOutput({tag, " err"}, 32'(resp_err), 32'(e.err));
        checkOutput({tag, " stall cycles"}, 32'(stallCnt), 32'(e.lat + 1));

        @(posedge clk);
        #1;
        checkOutput({tag, " pulse end"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " data held"}, resp_data, e.data);
        checkOutput({tag, " idle ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " idle stall"}, 32'(stall), 32'd0);
    endtask

    // Hard stop in case anything above stops advancing.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        int         respSeen;
        logic [2:0] f3;
        logic [31:0] ra;
        logic [31:0] rb;
        ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_a      = '0;
        req_b      = '0;
        ex_alu_op  = 4'b0011;
        ex_alu_a   = '0;
        ex_alu_b   = '0;
        #1;
        checkOutput("reset ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_err", 32'(resp_err), 32'd0);
        checkOutput("reset resp_data", resp_data, 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle pass-through of a pipeline XOR.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ex_alu_a = $urandom();
            ex_alu_b = $urandom();
            #1;
            checkOutput("pass op", 32'(alu_op), 32'h3);
            checkOutput("pass a", alu_a, ex_alu_a);
            checkOutput("pass b", alu_b, ex_alu_b);
            checkOutput("pass result", alu_result, ex_alu_a ^ ex_alu_b);
            checkOutput("pass stall", 32'(stall), 32'd0);
        end

        applyStimulus(3'b000, 32'h0000_1234, 32'h0000_5678, "mul", 1'b0);
        checkOutput("mul const", resp_data, 32'h0626_0060);
        applyStimulus(3'b100, 32'hFFFF_FF9C, 32'h0000_0007, "div neg", 1'b1);
        checkOutput("div neg const", resp_data, 32'hFFFF_FFF2);
        applyStimulus(3'b110, 32'hFFFF_FF9C, 32'h0000_0007, "rem neg", 1'b0);
        checkOutput("rem neg const", resp_data, 32'hFFFF_FFFE);
        applyStimulus(3'b101, 32'h0000_000A, 32'h0000_0000, "divu zero", 1'b0);
        applyStimulus(3'b111, 32'h0000_000A, 32'h0000_0000, "remu zero", 1'b0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 1'b0);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", 1'b0);
        applyStimulus(3'b100, 32'h0000_0064, 32'h0000_0000, "div zero", 1'b0);
        applyStimulus(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, "mulh", 1'b0);
        applyStimulus(3'b011, 32'h0000_0003, 32'h0000_0005, "mulhu", 1'b0);
        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, "mul neg", 1'b0);
        applyStimulus(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, "divu big", 1'b0);
        applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, "remu big", 1'b0);

        for (int k = 0; k < 4; k++) begin
            f3 = ops[$urandom_range(0, 4)];
            ra = $urandom();
            rb = $urandom();
            applyStimulus(f3, ra, rb, "random", 1'b0);
        end

        // Abort a DIV partway through with reset.
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b100;
        req_a      = 32'h0001_0000;
        req_b      = 32'h0000_0003;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort ready", 32'(req_ready), 32'd1);
        checkOutput("abort resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("abort stall", 32'(stall), 32'd0);
        checkOutput("abort resp_data", resp_data, 32'd0);
        checkOutput("abort pass a", alu_a, ex_alu_a);
        checkOutput("abort pass op", 32'(alu_op), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        respSeen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) respSeen++;
        end
        checkOutput("abort no response", 32'(respSeen), 32'd0);

        applyStimulus(3'b000, 32'd3, 32'd5, "mul 3x5", 1'b0);
        checkOutput("mul 3x5 const", resp_data, 32'd15);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
